// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave time-entry path.
package microwave_pkg;

  localparam int BCD_W        = 4;
  localparam int SEC_TENS_MAX = 5;

  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} kp_state_e;

  // Keypad bit 9..1 carries keys 1..9; bit 0 is key 0.
  function automatic logic [BCD_W-1:0] key_to_bcd(input logic [9:0] k);
    logic [BCD_W-1:0] b;
    b = '0;
    for (int i = 1; i < 10; i++)
      if (k[i]) b = BCD_W'(10 - i);
    return b;
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// Keypad sampler, debounce FSM and press qualifier; emits one accept_pulse per clean press.
// Optional KEYPAD_SYNC_EN inserts a 2-flop synchroniser in front of kp_q.
module key_debouncer
  import microwave_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic       clk,
  input  logic       clear,
  input  logic [9:0] keypad,
  input  logic       enable,
  output logic       accept_pulse,
  output logic [9:0] candidate
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [9:0]       kp_in, kp_q, cand_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             accept_nxt;
  logic             kp_valid, kp_released;
  kp_state_e        state, state_nxt;

`ifdef KEYPAD_SYNC_EN
  logic [9:0] kp_s1, kp_s2;
  always_ff @(posedge clk) begin
    if (clear) begin
      kp_s1 <= '0;
      kp_s2 <= '0;
    end else begin
      kp_s1 <= keypad;
      kp_s2 <= kp_s1;
    end
  end
  assign kp_in = kp_s2;
`else
  assign kp_in = keypad;
`endif

  assign kp_released = (kp_q == '0);
  assign kp_valid    = !kp_released && ((kp_q & (kp_q - 10'd1)) == '0);

  always_ff @(posedge clk) begin
    if (clear) begin
      kp_q         <= '0;
      state        <= IDLE;
      cnt          <= '0;
      candidate    <= '0;
      accept_pulse <= 1'b0;
    end else begin
      kp_q         <= kp_in;
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      candidate    <= cand_nxt;
      accept_pulse <= accept_nxt;
    end
  end

  // A single-cycle debounce accepts or releases on the first qualifying sample.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    cand_nxt   = candidate;
    accept_nxt = 1'b0;
    if (enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (kp_valid) begin
          cand_nxt = kp_q;
          cnt_nxt  = CNT_ONE;
          if (DEBOUNCE_CYCLES == 1) begin
            accept_nxt = 1'b1;
            state_nxt  = HELD;
          end else begin
            state_nxt  = PRESS_DB;
          end
        end
        PRESS_DB: begin
          if (kp_q != candidate) begin
            state_nxt = IDLE;
          end else if (cnt == CNT_LAST) begin
            accept_nxt = 1'b1;
            state_nxt  = HELD;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        HELD: if (kp_released) begin
          cnt_nxt   = CNT_ONE;
          state_nxt = (DEBOUNCE_CYCLES == 1) ? IDLE : REL_DB;
        end
        REL_DB: begin
          if (!kp_released)         state_nxt = HELD;
          else if (cnt == CNT_LAST) state_nxt = IDLE;
          else                      cnt_nxt   = cnt + CNT_ONE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: rtl/keypad_entry.sv
// Keypad time-entry front end: debounced key strobes shifted into an M:ST:SO register.
// Build option KEYPAD_SYNC_EN adds a 2-flop input synchroniser (+2 cycles latency).
module keypad_entry
  import microwave_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [9:0]       keypad,
  input  logic             enable,
  output logic [BCD_W-1:0] digit,
  output logic             digit_valid,
  output logic             digit_reject,
  output logic [BCD_W-1:0] sec_ones,
  output logic [BCD_W-1:0] sec_tens,
  output logic [BCD_W-1:0] mins,
  output logic [1:0]       digit_count
);

  logic             accept_pulse;
  logic [9:0]       candidate;
  logic [BCD_W-1:0] cand_bcd;

  key_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_deb (
    .clk          (clk),
    .clear        (clear),
    .keypad       (keypad),
    .enable       (enable),
    .accept_pulse (accept_pulse),
    .candidate    (candidate)
  );

  assign cand_bcd = key_to_bcd(candidate);

  // Shifting a digit >5 into sec_tens would make an illegal time, so refuse it.
  always_ff @(posedge clk) begin
    if (clear) begin
      digit        <= '0;
      digit_valid  <= 1'b0;
      digit_reject <= 1'b0;
      sec_ones     <= '0;
      sec_tens     <= '0;
      mins         <= '0;
      digit_count  <= '0;
    end else begin
      digit_valid  <= 1'b0;
      digit_reject <= 1'b0;
      if (accept_pulse && !enable) begin
        digit <= cand_bcd;
        if (sec_ones <= BCD_W'(SEC_TENS_MAX)) begin
          digit_valid <= 1'b1;
          mins        <= sec_tens;
          sec_tens    <= sec_ones;
          sec_ones    <= cand_bcd;
          if (digit_count != 2'd3) digit_count <= digit_count + 2'd1;
        end else begin
          digit_reject <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_entry.sv
// Self-checking bench for keypad_entry: vector table plus strobe scoreboard.
module tb_keypad_entry;

  localparam int DB = 4;
`ifdef KEYPAD_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif

  logic       clk = 1'b0;
  logic       clear, enable;
  logic [9:0] keypad;
  logic [3:0] digit, sec_ones, sec_tens, mins;
  logic       digit_valid, digit_reject;
  logic [1:0] digit_count;

  keypad_entry #(.DEBOUNCE_CYCLES(DB), .CNT_W(8)) dut (
    .clk(clk), .clear(clear), .keypad(keypad), .enable(enable),
    .digit(digit), .digit_valid(digit_valid), .digit_reject(digit_reject),
    .sec_ones(sec_ones), .sec_tens(sec_tens), .mins(mins), .digit_count(digit_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] dg;
    logic       v;
    logic       rj;
    logic [3:0] so;
    logic [3:0] st;
    logic [3:0] m;
    logic [1:0] cnt;
  } obs_t;

  typedef struct {
    logic [9:0] key;
    obs_t       exp;
  } vec_t;

  int   nvec = 0;
  int   nerr = 0;
  obs_t sb[$];
  vec_t tbl[6];

  function automatic obs_t cur_obs();
    obs_t o;
    o.dg = digit; o.v = digit_valid; o.rj = digit_reject;
    o.so = sec_ones; o.st = sec_tens; o.m = mins; o.cnt = digit_count;
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock; outputs sampled on the falling edge, any strobe scored against the queue.
  task automatic tick();
    obs_t e;
    @(posedge clk);
    @(negedge clk);
    if (digit_valid || digit_reject) begin
      if (sb.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL spurious_strobe: got %h expected no strobe", cur_obs());
      end else begin
        e = sb.pop_front();
        check("strobe", 32'(cur_obs()), 32'(e));
      end
    end
  endtask

  task automatic press(input logic [9:0] k, input int hold, input int rel);
    keypad = k;
    repeat (hold) tick();
    keypad = '0;
    repeat (rel) tick();
  endtask

  task automatic check_regs(input string name, input logic [3:0] so, input logic [3:0] st,
                            input logic [3:0] m, input logic [1:0] c);
    check(name, {18'd0, sec_ones, sec_tens, mins, digit_count}, {18'd0, so, st, m, c});
  endtask

  task automatic check_zero(input string name);
    check(name, 32'(cur_obs()), 32'd0);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    repeat (2) tick();
    clear = 1'b0;
    check_zero("clear_zero");
  endtask

  function automatic obs_t mk(input logic [3:0] dg, input logic v, input logic rj,
                              input logic [3:0] so, input logic [3:0] st,
                              input logic [3:0] m, input logic [1:0] c);
    obs_t o;
    o.dg = dg; o.v = v; o.rj = rj; o.so = so; o.st = st; o.m = m; o.cnt = c;
    return o;
  endfunction

  initial begin
    // keys: 1=bit9, 3=bit7, 0=bit0, 5=bit5, 7=bit3, 2=bit8
    tbl[0] = '{10'h200, mk(4'd1, 1'b1, 1'b0, 4'd1, 4'd0, 4'd0, 2'd1)};
    tbl[1] = '{10'h080, mk(4'd3, 1'b1, 1'b0, 4'd3, 4'd1, 4'd0, 2'd2)};
    tbl[2] = '{10'h001, mk(4'd0, 1'b1, 1'b0, 4'd0, 4'd3, 4'd1, 2'd3)};
    tbl[3] = '{10'h020, mk(4'd5, 1'b1, 1'b0, 4'd5, 4'd0, 4'd3, 2'd3)};
    tbl[4] = '{10'h008, mk(4'd7, 1'b1, 1'b0, 4'd7, 4'd5, 4'd0, 2'd3)};
    tbl[5] = '{10'h100, mk(4'd2, 1'b0, 1'b1, 4'd7, 4'd5, 4'd0, 2'd3)};

    clear = 1'b1; enable = 1'b0; keypad = '0;
    repeat (2) tick();
    clear = 1'b0;
    check_zero("reset");

    // Key 3 held 10 cycles: strobe lands exactly after edge DB+1, once.
    keypad = 10'h080;
    sb.push_back(mk(4'd3, 1'b1, 1'b0, 4'd3, 4'd0, 4'd0, 2'd1));
    repeat (DB + SYNC + 1) tick();
    check("early_valid", 32'(digit_valid), 32'd0);
    tick();
    check("latency_valid", 32'(digit_valid), 32'd1);
    check("latency_digit", 32'(digit), 32'd3);
    check_regs("latency_regs", 4'd3, 4'd0, 4'd0, 2'd1);
    tick();
    check("strobe_width", 32'(digit_valid), 32'd0);
    repeat (10 - (DB + SYNC + 3)) tick();
    keypad = '0;
    repeat (10) tick();
    check("held_once", 32'(sb.size()), 32'd0);

    do_clear();

    // Entry sequence 1,3,0,5,7 then 2 (refused: sec_ones is 7).
    for (int i = 0; i < 6; i++) begin
      sb.push_back(tbl[i].exp);
      press(tbl[i].key, 10, 10);
      check($sformatf("strobe_seen_%0d", i), 32'(sb.size()), 32'd0);
    end

    do_clear();

    // Bounce 1-0-1 then stable: exactly one strobe.
    keypad = 10'h080; tick();
    keypad = '0;      tick();
    sb.push_back(mk(4'd3, 1'b1, 1'b0, 4'd3, 4'd0, 4'd0, 2'd1));
    press(10'h080, 10, 10);
    check("bounce_one", 32'(sb.size()), 32'd0);

    // Two keys together: ignored.
    press(10'h084, 10, 10);
    check_regs("multikey_hold", 4'd3, 4'd0, 4'd0, 2'd1);

    // Locked while magnetron runs.
    enable = 1'b1;
    press(10'h040, 10, 10);
    enable = 1'b0;
    tick();
    check_regs("lock_hold", 4'd3, 4'd0, 4'd0, 2'd1);

    // clear on the accepting edge wins.
    keypad = 10'h200;
    repeat (DB + SYNC) tick();
    clear  = 1'b1;
    keypad = '0;
    tick();
    clear = 1'b0;
    check_zero("clear_on_accept");
    repeat (10) tick();
    check_zero("clear_after");

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/keypad_entry.md
Name: keypad_entry

Overview:
- Upstream front end of the microwave time-entry path, between the raw 10-key keypad and the countdown timer and display decoder.
- Registers the keypad, debounces it, and rejects multi-key or glitch presses.
- Turns each clean press into one BCD digit strobe and shifts digits into a 3-digit entry register (M:ST:SO).
- The register is presented in parallel to the timer load path and the display.
- Entry is locked while the magnetron is enabled.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive identical registered samples required to accept a press or a release; legal range 1..255.
- CNT_W, 8: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock, all logic on posedge
- clear  in  1  synchronous active-high reset; also the user CLEAR key
- keypad  in  10  raw keys; bit9=1, bit8=2, bit7=3, bit6=4, bit5=5, bit4=6, bit3=7, bit2=8, bit1=9, bit0=0
- enable  in  1  magnetron running; 1 = keypad locked
- digit  out  4  BCD of last accepted key
- digit_valid  out  1  one-cycle strobe per accepted key
- digit_reject  out  1  one-cycle strobe when a debounced key is refused (seconds-tens rule)
- sec_ones  out  4  entry register, seconds units
- sec_tens  out  4  entry register, seconds tens (always 0..5)
- mins  out  4  entry register, minutes (0..9)
- digit_count  out  2  accepted digits since clear, saturates at 3

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, on port clear.
- Reset, sampled at the clk edge: every output is 0, the FSM goes to IDLE, debounce counter and kp_q go to 0.
- clear takes priority over every other event, including a press completing on the same edge.
- kp_q is keypad registered every cycle. A sample is "valid" if kp_q is exactly one-hot; all-zero is "released"; anything else is "invalid".
- FSM states: IDLE, PRESS_DB, HELD, REL_DB.
- IDLE:
  - kp_q valid and enable=0 -> latch candidate=kp_q, cnt=1, go to PRESS_DB.
- PRESS_DB:
  - kp_q==candidate -> cnt++.
  - When cnt reaches DEBOUNCE_CYCLES, the press is accepted on that edge; go to HELD.
  - kp_q!=candidate (change, release, multi-key) -> IDLE, no strobe.
- Acceptance, in the cycle after the accepting edge:
  - digit = BCD(candidate).
  - If current sec_ones<=5: digit_valid=1; shift mins<=sec_tens, sec_tens<=sec_ones, sec_ones<=digit; digit_count++ (saturating at 3).
  - If sec_ones>5: digit_reject=1; registers and count unchanged.
- HELD:
  - Wait while kp_q==candidate; no auto-repeat.
  - On released -> cnt=1, go to REL_DB.
  - On invalid or a different key -> stay in HELD; a new press needs a full release first.
- REL_DB:
  - released for DEBOUNCE_CYCLES consecutive samples -> IDLE.
  - Any non-zero sample -> HELD.
- Lock: enable=1 in any state forces IDLE on the next edge and suppresses strobes. Entry registers hold their values; the timer owns the count.
- Shift overflow: once 3 digits are held, the next accepted digit discards the old mins value.
- Latency: with keypad stable one-hot before edge 0, kp_q updates at edge 0 and the press is accepted at edge DEBOUNCE_CYCLES. digit_valid and the updated registers are visible after edge DEBOUNCE_CYCLES+1.
- Strobes are registered, exactly one cycle wide, and mutually exclusive.

Optional Feature:
- Macro: KEYPAD_SYNC_EN.
- Defined: keypad passes through a 2-flop synchroniser before kp_q, and all latencies grow by 2 cycles. The synchroniser flops also reset under clear.
- Undefined: keypad is sampled directly into kp_q (inputs assumed synchronous).

Decomposition:
- Package microwave_pkg holds:
  - FSM state enum (IDLE, PRESS_DB, HELD, REL_DB).
  - BCD_W=4, SEC_TENS_MAX=5.
  - Keypad-bit-to-BCD constant function.
- Sub-module key_debouncer contains kp_q, the optional synchroniser, the FSM and the counter, and outputs accept_pulse and candidate.
- keypad_entry top contains BCD conversion, the tens rule, the shift register, digit_count and output strobes.

Test Plan:
- Reset: clear=1 for 2 cycles -> all outputs 0; FSM IDLE.
- Press key "3" (bit7), held 10 cycles, DEBOUNCE_CYCLES=4 -> after edge 5: digit_valid=1 for exactly 1 cycle, digit=3, sec_ones=3, digit_count=1. No second strobe while held.
- Enter 1,3,0 with full releases -> mins=1, sec_tens=3, sec_ones=0, digit_count=3. Then enter 5 -> mins=3, sec_tens=0, sec_ones=5.
- Bounce: bit7 toggles 1-0-1 within 3 cycles, then stable -> single strobe only after 4 stable samples. bit7|bit2 together -> no strobe.
- Tens rule: enter 7 then 2 -> first accepted (sec_ones=7); second gives digit_reject=1, digit_valid=0, registers unchanged.
- Lock and clear: enable=1 while pressing 4 -> no strobe, registers hold. clear asserted on the accepting edge -> no strobe, all outputs 0.
